// File: rtl/loader_pkg.sv
// Shared types and constants for the serial program loader.
package loader_pkg;

  // Loader FSM states; StCsum is only reachable in checksum builds.
  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StCsum,
    StDone,
    StErr
  } loader_state_e;

  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

  // Clock cycles per UART bit, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, glitch-rejecting start bit.
module uart_rx
  import loader_pkg::*;
#(
  parameter int unsigned CLK_HZ = 23_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned Div  = baud_div(CLK_HZ, BAUD);
  localparam int unsigned CntW = (Div > 2) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntFull = CntW'(Div - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(Div / 2 - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  rx_state_e       state_q, state_d;
  logic            sync1_q, sync2_q, prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  // Next-state: a start needs a falling edge, so a line held low after a
  // framing error cannot retrigger until it returns high.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      RxIdle: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = RxStart;
      end
      RxStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = sync2_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (cnt_q == CntFull) begin
          cnt_d     = '0;
          shreg_d   = {sync2_q, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = RxStop;
        end
      end
      RxStop: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          state_d = RxIdle;
          valid_d = sync2_q;
          err_d   = !sync2_q;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  // Synchronizer and receiver state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      state_q   <= RxIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync1_q   <= rxd;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = shreg_q;
  assign frame_err  = err_q;

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: receives a length-prefixed image over UART and writes
// it word by word into the instruction memory while holding the CPU in reset.
// Optional feature: define PROG_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte before the image is declared done.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLK_HZ = 23_000_000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              uart_rxd,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [16:0] MaxWords = 17'(1) << ADDR_W;

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ferr;

  uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .clock      (clock),
    .reset_n    (reset_n),
    .rxd        (uart_rxd),
    .byte_valid (rx_valid),
    .byte_data  (rx_data),
    .frame_err  (rx_ferr)
  );

  loader_state_e     state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       n_q, n_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       asm_q, asm_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              hold_q, hold_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic [16:0]     n_rx;
  logic [ADDR_W:0] words_inc;
  logic            last_word;
  loader_state_e   st_finish;

  assign n_rx      = {1'b0, rx_data, len_lo_q};
  assign words_inc = words_q + (ADDR_W + 1)'(1);
  assign last_word = (17'(words_inc) == {1'b0, n_q});
`ifdef PROG_LOADER_CHECKSUM_EN
  assign st_finish = StCsum;
`else
  assign st_finish = StDone;
`endif

  // Next-state: start overrides everything, including a coincident byte.
  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    n_d        = n_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    words_d    = words_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    if (start) begin
      state_d    = StLenLo;
      words_d    = '0;
      addr_d     = '0;
      byte_idx_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_d     = '0;
`endif
    end else begin
      unique case (state_q)
        StLenLo: begin
          if (rx_ferr) begin
            state_d = StErr;
          end else if (rx_valid) begin
            len_lo_d = rx_data;
            state_d  = StLenHi;
          end
        end
        StLenHi: begin
          if (rx_ferr) begin
            state_d = StErr;
          end else if (rx_valid) begin
            n_d = {rx_data, len_lo_q};
            if (n_rx == 17'd0)         state_d = st_finish;
            else if (n_rx > MaxWords)  state_d = StErr;
            else                       state_d = StData;
          end
        end
        StData: begin
          // Address and count advance as the strobe ends, keeping them stable during it.
          if (we_q) begin
            words_d = words_inc;
            addr_d  = addr_q + ADDR_W'(1);
            if (last_word) state_d = st_finish;
          end
          if (rx_ferr) begin
            state_d = StErr;
          end else if (rx_valid) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_d = csum_q ^ rx_data;
`endif
            if (byte_idx_q == 2'(BYTES_PER_WORD - 1)) begin
              we_d       = 1'b1;
              wdata_d    = {rx_data, asm_q};
              byte_idx_d = '0;
            end else begin
              asm_d      = {rx_data, asm_q[23:8]};
              byte_idx_d = byte_idx_q + 2'd1;
            end
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        StCsum: begin
          if (rx_ferr) begin
            state_d = StErr;
          end else if (rx_valid) begin
            state_d = (rx_data == csum_q) ? StDone : StErr;
          end
        end
`endif
        default: ;
      endcase
    end
    done_d  = (state_d == StDone);
    error_d = (state_d == StErr);
    hold_d  = (state_d == StLenLo) || (state_d == StLenHi) || (state_d == StData) ||
              (state_d == StCsum) || (state_d == StErr);
  end

  // Loader state and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      len_lo_q   <= '0;
      n_q        <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      words_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      hold_q     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      n_q        <= n_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      words_q    <= words_d;
      done_q     <= done_d;
      error_q    <= error_d;
      hold_q     <= hold_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed UART frames, a frame-level
// model predicting the memory writes and final status, and literal pins.
module tb_prog_loader;

  localparam int unsigned CLK_HZ  = 1_000_000;
  localparam int unsigned BAUD    = 100_000;
  localparam int unsigned ADDR_W  = 14;
  localparam int          BIT_CYC = 10;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              uart_rxd = 1'b1;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  prog_loader #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .ADDR_W (ADDR_W)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .uart_rxd     (uart_rxd),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    bit                last;
  } wr_t;

  int total = 0;
  int bad = 0;
  wr_t exp_q[$];
  logic [31:0] log_data[$];
  logic [ADDR_W-1:0] log_addr[$];
  wr_t w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Frame-level model: derive writes and final status from the byte stream.
  task automatic predict(input byte_q_t b, input int bad_idx, output bit e_done,
                         output bit e_err, output int e_words);
    int n;
    int base;
    logic [7:0] x;
    e_done = 0; e_err = 0; e_words = 0;
    if (bad_idx == 0 || bad_idx == 1) begin e_err = 1; return; end
    n = int'(b[0]) + 256 * int'(b[1]);
    if (n > (1 << ADDR_W)) begin e_err = 1; return; end
    for (int k = 0; k < n; k++) begin
      base = 2 + 4 * k;
      if (bad_idx >= 0 && bad_idx < base + 4) begin e_err = 1; return; end
      if (b.size() < base + 4) return;
      exp_q.push_back('{addr: ADDR_W'(k),
                        data: {b[base+3], b[base+2], b[base+1], b[base]},
                        last: (k == n - 1)});
      e_words++;
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    base = 2 + 4 * n;
    if (bad_idx == base) begin e_err = 1; return; end
    if (b.size() <= base) return;
    x = 8'h00;
    for (int i = 2; i < base; i++) x = x ^ b[i];
    if (b[base] == x) e_done = 1;
    else e_err = 1;
`else
    x = 8'h00;
    e_done = (x == 8'h00);
`endif
  endtask

  // Append the XOR checksum byte in checksum builds; identity otherwise.
  function automatic byte_q_t framed(input byte_q_t b);
    byte_q_t r = b;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    for (int i = 2; i < b.size(); i++) x = x ^ b[i];
    r.push_back(x);
`endif
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop_low);
    @(negedge clock) uart_rxd = 1'b0;
    repeat (BIT_CYC) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BIT_CYC) @(negedge clock);
    end
    uart_rxd = !stop_low;
    repeat (BIT_CYC) @(negedge clock);
    uart_rxd = 1'b1;
    repeat (2 * BIT_CYC) @(negedge clock);
  endtask

  task automatic pulse_start(input string tag);
    @(negedge clock) start = 1'b1;
    @(posedge clock); #1;
    check({tag, "_hold_after_start"}, {31'b0, cpu_hold}, 32'd1);
    @(negedge clock) start = 1'b0;
  endtask

  task automatic run_session(input string tag, input byte_q_t b, input int bad_idx);
    bit e_done, e_err;
    int e_words;
    log_data.delete();
    log_addr.delete();
    predict(b, bad_idx, e_done, e_err, e_words);
    pulse_start(tag);
    for (int i = 0; i < b.size(); i++) send_byte(b[i], (i == bad_idx));
    repeat (5) @(posedge clock);
    #1;
    check({tag, "_done"}, {31'b0, done}, {31'b0, e_done});
    check({tag, "_error"}, {31'b0, error}, {31'b0, e_err});
    check({tag, "_cpu_hold"}, {31'b0, cpu_hold}, {31'b0, !e_done});
    check({tag, "_words_loaded"}, 32'(words_loaded), e_words);
    check({tag, "_writes_pending"}, exp_q.size(), 0);
  endtask

  // Compare process: every memory write must match the model's next expected write.
  initial begin
    bit done_chk = 0;
    forever begin
      @(posedge clock); #1;
      if (done_chk) begin
        check("done_after_last_write", {31'b0, done}, 32'd1);
        check("hold_after_last_write", {31'b0, cpu_hold}, 32'd0);
        done_chk = 0;
      end
      if (imem_we === 1'b1) begin
        log_data.push_back(imem_wdata);
        log_addr.push_back(imem_addr);
        if (exp_q.size() == 0) begin
          check("unexpected_write", {31'b0, imem_we}, 32'd0);
        end else begin
          w = exp_q.pop_front();
          check("write_addr", 32'(imem_addr), 32'(w.addr));
          check("write_data", imem_wdata, w.data);
`ifndef PROG_LOADER_CHECKSUM_EN
          if (w.last) done_chk = 1;
`endif
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit e_done, e_err;
    int e_words;
    byte_q_t s;

    // Reset state.
    #1;
    check("rst_we", {31'b0, imem_we}, 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_hold", {31'b0, cpu_hold}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_error", {31'b0, error}, 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    repeat (4) @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);

    // Two-word image.
    run_session("two_words", framed('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                                      8'h08, 8'h00, 8'h00, 8'h00}), -1);
    check("two_words_log_count", log_data.size(), 2);
    if (log_data.size() >= 2) begin
      check("two_words_w0", log_data[0], 32'h0000_0013);
      check("two_words_a1", 32'(log_addr[1]), 32'd1);
      check("two_words_w1", log_data[1], 32'h0000_0008);
    end
    check("two_words_count_pin", 32'(words_loaded), 32'd2);

    // Empty image.
    run_session("empty", framed('{8'h00, 8'h00}), -1);
    check("empty_no_writes", log_data.size(), 0);
    check("empty_done_pin", {31'b0, done}, 32'd1);

    // Oversized length 0x4001.
    run_session("too_long", '{8'h01, 8'h40}, -1);
    check("too_long_error_pin", {31'b0, error}, 32'd1);
    check("too_long_hold_pin", {31'b0, cpu_hold}, 32'd1);
    check("too_long_no_writes", log_data.size(), 0);

    // Framing error on the third data byte, then recovery.
    run_session("frame_err", '{8'h02, 8'h00, 8'hA1, 8'hA2, 8'hA3}, 4);
    check("frame_err_error_pin", {31'b0, error}, 32'd1);
    check("frame_err_no_writes", log_data.size(), 0);
    run_session("recover", framed('{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}), -1);
    check("recover_error_pin", {31'b0, error}, 32'd0);
    if (log_data.size() >= 1) check("recover_w0", log_data[0], 32'hDEAD_BEEF);

    // Asynchronous reset after five data bytes.
    log_data.delete();
    log_addr.delete();
    s = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    predict(s, -1, e_done, e_err, e_words);
    pulse_start("reset_mid");
    for (int i = 0; i < s.size(); i++) send_byte(s[i], 1'b0);
    @(negedge clock) uart_rxd = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("reset_mid_we", {31'b0, imem_we}, 32'd0);
    check("reset_mid_addr", 32'(imem_addr), 32'd0);
    check("reset_mid_wdata", imem_wdata, 32'd0);
    check("reset_mid_hold", {31'b0, cpu_hold}, 32'd0);
    check("reset_mid_done", {31'b0, done}, 32'd0);
    check("reset_mid_error", {31'b0, error}, 32'd0);
    check("reset_mid_words", 32'(words_loaded), 32'd0);
    repeat (5) @(negedge clock);
    uart_rxd = 1'b1;
    reset_n = 1'b1;
    repeat (20 * BIT_CYC) @(negedge clock);
    #1;
    check("reset_mid_one_write", log_data.size(), 1);
    if (log_data.size() >= 1) check("reset_mid_w0", log_data[0], 32'h4433_2211);
    check("reset_mid_writes_pending", exp_q.size(), 0);
    check("reset_mid_idle_hold", {31'b0, cpu_hold}, 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
    run_session("csum_ok", '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00}, -1);
    check("csum_ok_done_pin", {31'b0, done}, 32'd1);
    run_session("csum_bad", '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01}, -1);
    check("csum_bad_error_pin", {31'b0, error}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Serial program loader: the write side of the instruction memory that the fetch stage reads. It receives a length-prefixed program image over a UART line and writes it, one 32-bit word per write, into the instruction ROM's second port. While loading, it holds the CPU in reset. It sits beside the fetch stage at the top level, and its `cpu_hold` output is ORed into the CPU reset.

## Interface
Parameters:
- `CLK_HZ`, default 23_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: UART bit rate.
- `ADDR_W`, default 14: word-address width, equal to the instruction memory address width.

Ports:
- `clock`, input, 1: single system clock. All logic is rising-edge.
- `reset_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: one-cycle pulse that opens a load session.
- `uart_rxd`, input, 1: asynchronous serial input, idle high, 8N1.
- `imem_we`, output, 1: instruction memory write strobe.
- `imem_addr`, output, ADDR_W: word address (byte address >> 2).
- `imem_wdata`, output, 32: instruction word.
- `cpu_hold`, output, 1: holds the CPU in reset while high.
- `done`, output, 1: sticky; the image loaded successfully.
- `error`, output, 1: sticky; the session aborted.
- `words_loaded`, output, ADDR_W+1: number of words written this session.

## Operation
- **Frame layout:**
  - LEN_LO byte, then LEN_HI byte: N, 16-bit little-endian.
  - Then N×4 data bytes, each word little-endian (first byte goes to bits [7:0]).
- **States:** IDLE, LEN_LO, LEN_HI, DATA, CSUM (only with the macro), DONE, ERR.
- **Transitions:**
  - IDLE → LEN_LO on `start`. `start` in any state restarts at LEN_LO and clears `done`, `error`, `words_loaded`, the address and the byte index.
  - LEN_LO → LEN_HI on a byte.
  - LEN_HI → DATA on a byte if 0 < N ≤ 2^ADDR_W.
  - LEN_HI → DONE (or CSUM) if N = 0.
  - LEN_HI → ERR if N > 2^ADDR_W.
  - DATA: a 2-bit byte index shifts each byte into the assembly register. On the 4th byte, write the word at `imem_addr`, increment the address and `words_loaded`, and clear the index.
  - DATA → DONE (or CSUM) after the Nth write.
  - Any receive state → ERR on a framing error (stop bit sampled low).
- **Outputs:**
  - `cpu_hold` is high in LEN_LO, LEN_HI, DATA, CSUM and ERR. It is low in IDLE and DONE.
  - On error, the CPU stays held until the next `start` or reset, so a partial image never runs.
- **Address counting:** the address counter is ADDR_W bits and cannot wrap within a session, because N is range-checked.
- **uart_rx sub-block:**
  - Two-flop synchronizer on `uart_rxd`.
  - Start bit is validated at its mid-bit point. Each bit is sampled at mid-bit.
  - Divisor is CLK_HZ/BAUD, rounded.
  - Produces a one-cycle `byte_valid` with `byte_data`, plus a `frame_err` pulse.
  - A start bit that reads high at mid-bit is discarded as a glitch.

## Timing
- **Reset values:** state IDLE; all outputs 0; `imem_addr` 0; `imem_wdata` 0.
- **Start:** `cpu_hold` rises the cycle after `start` is sampled.
- **Write strobe:** `imem_we` is high for exactly one cycle, the cycle after the `byte_valid` of the 4th byte. `imem_addr` and `imem_wdata` are stable during that cycle. `words_loaded` updates on the same edge the strobe ends.
- **Completion:**
  - `done` rises and `cpu_hold` falls together, one cycle after the final write strobe (or after the CSUM byte).
  - `error` rises one cycle after the offending byte or frame error.
- **Collisions:** if `start` coincides with `byte_valid`, `start` wins and the byte is dropped.
- **Async reset mid-frame:** returns to IDLE immediately. Any write in flight is suppressed.

## Configuration
- **`PROG_LOADER_CHECKSUM_EN` defined:**
  - After the data bytes, state CSUM consumes one byte and compares it against the XOR of all N×4 data bytes.
  - Match → DONE. Mismatch → ERR.
  - Words are still written during DATA, so `error` marks the image invalid.
- **Undefined:** no CSUM state, and DATA goes directly to DONE.

## Structure
- **Shared package `loader_pkg`:**
  - State enum.
  - `LEN_BYTES = 2`.
  - `BYTES_PER_WORD = 4`.
  - Baud-divisor function.
- **Sub-module `uart_rx`:** parameters CLK_HZ and BAUD. Outputs `byte_valid`, `byte_data[7:0]`, `frame_err`.
- The top-level FSM, assembly register, counters and checksum live in `prog_loader`.

## Test plan
- Reset, then `start`, then bytes 02 00 13 00 00 00 08 00 00 00 → writes 0x00000013 @0 and 0x00000008 @1; `words_loaded`=2; `done`=1; `cpu_hold`=0.
- N = 0 (00 00) → no `imem_we`; `done`=1 one cycle after LEN_HI.
- N = 0x4001 (ADDR_W=14) → `error`=1 after LEN_HI; `cpu_hold` stays 1; no writes.
- Stop bit forced low on the 3rd data byte → `error`=1; 0 words written; next `start` plus a valid 1-word image → `done`=1, `error`=0.
- `reset_n` low after 5 data bytes → all outputs 0 immediately; second word never written.
- With the macro, 1 word AA BB CC DD then checksum 0x00 → `done`; checksum 0x01 → `error`.
